// File: rtl/running_average_win.sv
// rtl/running_average_win.sv - valid-qualified moving average over the last 2^k samples, k selectable at run time
// Optional round-half-up of the average when RUNAVG_ROUND_EN is defined; truncation otherwise.
module running_average_win #(
    parameter int DATA_W   = 32,
    parameter int MAX_LOG2 = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear_i,
    input  logic [$clog2(MAX_LOG2+1)-1:0]    win_log2_i,
    input  logic                             valid_i,
    input  logic [DATA_W-1:0]                data_i,
    output logic                             valid_o,
    output logic [DATA_W-1:0]                average_o,
    output logic                             full_o
);
    localparam int K_W   = $clog2(MAX_LOG2 + 1);
    localparam int ACC_W = DATA_W + MAX_LOG2;
    localparam int CNT_W = MAX_LOG2 + 1;
    localparam int PTR_W = MAX_LOG2;
    localparam int DEPTH = 1 << MAX_LOG2;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ACC_W-1:0]  sum_q,   sum_d;
    logic [PTR_W-1:0]  ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [K_W-1:0]    k_q,     k_d;
    logic              init_q,  init_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] avg_q,   avg_d;
    logic              full_q,  full_d;

    logic [K_W-1:0]    k_clamp;
    logic [K_W-1:0]    k_eff;
    logic [CNT_W-1:0]  win_size;
    logic [PTR_W-1:0]  ptr_mask;
    logic [DATA_W-1:0] oldest;
    logic [ACC_W-1:0]  sum_next;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] avg_next;
`ifdef RUNAVG_ROUND_EN
    logic [ACC_W:0]    rnd_sum;
    logic [ACC_W:0]    rnd_half;
`endif

    always_comb begin
        k_clamp  = (win_log2_i > K_W'(MAX_LOG2)) ? K_W'(MAX_LOG2) : win_log2_i;
        // Window size is only sampled on the first clock after reset and on clear
        k_eff    = (init_q || clear_i) ? k_clamp : k_q;
        win_size = CNT_W'(1) << k_eff;
        ptr_mask = PTR_W'(win_size - CNT_W'(1));
        oldest   = (cnt_q == win_size) ? mem_q[ptr_q] : '0;
        sum_next = sum_q + ACC_W'(data_i) - ACC_W'(oldest);
        cnt_next = (cnt_q == win_size) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef RUNAVG_ROUND_EN
        rnd_half = (k_eff == '0) ? '0 : ((ACC_W+1)'(1) << (k_eff - K_W'(1)));
        rnd_sum  = {1'b0, sum_next} + rnd_half;
        avg_next = DATA_W'(rnd_sum >> k_eff);
`else
        avg_next = DATA_W'(sum_next >> k_eff);
`endif

        sum_d   = sum_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        k_d     = k_eff;
        init_d  = 1'b0;
        valid_d = 1'b0;
        avg_d   = avg_q;
        full_d  = full_q;

        if (clear_i) begin
            sum_d  = '0;
            ptr_d  = '0;
            cnt_d  = '0;
            avg_d  = '0;
            full_d = 1'b0;
        end else if (valid_i) begin
            sum_d   = sum_next;
            ptr_d   = (ptr_q + PTR_W'(1)) & ptr_mask;
            cnt_d   = cnt_next;
            avg_d   = avg_next;
            full_d  = (cnt_next == win_size);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            init_q  <= 1'b1;
            valid_q <= 1'b0;
            avg_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            init_q  <= init_d;
            valid_q <= valid_d;
            avg_q   <= avg_d;
            full_q  <= full_d;
        end
    end

    // Sample RAM: the oldest slot is read combinationally above before this write lands
    always_ff @(posedge clk) begin
        if (valid_i && !clear_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

    assign valid_o   = valid_q;
    assign average_o = avg_q;
    assign full_o    = full_q;

endmodule

// File: tb/tb_running_average_win.sv
// tb/tb_running_average_win.sv - randomized and directed bench for running_average_win against a queue-based model
module tb_running_average_win;
    logic        clk = 1'b0;
    logic        reset;
    logic        clear_i;
    logic [2:0]  win_log2_i;
    logic        valid_i;
    logic [31:0] data_i;
    logic        valid_o;
    logic [31:0] average_o;
    logic        full_o;

    int errors = 0;
    int checks = 0;

    longint unsigned hist[$];
    int          mk;
    bit          minit;
    logic        e_valid;
    logic [31:0] e_avg;
    logic        e_full;

    running_average_win dut (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (clear_i),
        .win_log2_i (win_log2_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .average_o  (average_o),
        .full_o     (full_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, e_valid});
        chk({tag, ".avg"},   average_o,        e_avg);
        chk({tag, ".full"},  {31'b0, full_o},  {31'b0, e_full});
    endtask

    // Reference: average of the last 2^k accepted samples, missing samples counted as zero
    task automatic model_avg();
        longint unsigned s = 0;
        longint unsigned half;
        foreach (hist[i]) s += hist[i];
`ifdef RUNAVG_ROUND_EN
        half = (mk == 0) ? 0 : (64'd1 << (mk - 1));
`else
        half = 0;
`endif
        e_avg  = 32'((s + half) >> mk);
        e_full = (hist.size() == (1 << mk));
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic c, input logic [2:0] w);
        valid_i = v; data_i = d; clear_i = c; win_log2_i = w;
        @(posedge clk);
        #1;
        if (c || minit) mk = (w > 3'd4) ? 4 : int'(w);
        minit = 1'b0;
        if (c) begin
            hist.delete();
            e_valid = 1'b0; e_avg = '0; e_full = 1'b0;
        end else if (v) begin
            hist.push_back(longint'(d));
            while (hist.size() > (1 << mk)) void'(hist.pop_front());
            e_valid = 1'b1;
            model_avg();
        end else begin
            e_valid = 1'b0;
        end
        chk_outs(tag);
        valid_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic model_reset();
        hist.delete();
        e_valid = 1'b0; e_avg = '0; e_full = 1'b0;
        minit = 1'b1;
        mk = 0;
    endtask

    initial begin
        reset = 1'b1; clear_i = 1'b0; valid_i = 1'b0; data_i = '0; win_log2_i = 3'd2;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset");
        reset = 1'b0;

        // k=2 ramp: 1,3,6,10,14 with full on the 10
        step("ramp0", 1'b1, 32'd4,  1'b0, 3'd2);
        chk("ramp0.lit", average_o, 32'd1);
        step("ramp1", 1'b1, 32'd8,  1'b0, 3'd2);
        step("ramp2", 1'b1, 32'd12, 1'b0, 3'd2);
        step("ramp3", 1'b1, 32'd16, 1'b0, 3'd2);
        chk("ramp3.lit", average_o, 32'd10);
        chk("ramp3.full", {31'b0, full_o}, 32'd1);
        step("ramp4", 1'b1, 32'd20, 1'b0, 3'd2);
        chk("ramp4.lit", average_o, 32'd14);
        step("idle", 1'b0, 32'd99, 1'b0, 3'd2);

        // Rounding vs truncation: sum 7 over window 4
        step("rnd_clr", 1'b0, 32'd0, 1'b1, 3'd2);
        step("rnd0", 1'b1, 32'd1, 1'b0, 3'd2);
        step("rnd1", 1'b1, 32'd2, 1'b0, 3'd2);
        step("rnd2", 1'b1, 32'd2, 1'b0, 3'd2);
        step("rnd3", 1'b1, 32'd2, 1'b0, 3'd2);
`ifdef RUNAVG_ROUND_EN
        chk("rnd3.lit", average_o, 32'd2);
`else
        chk("rnd3.lit", average_o, 32'd1);
`endif

        // k=3 gapped all-ones samples: no accumulator overflow
        step("gap_clr", 1'b0, 32'd0, 1'b1, 3'd3);
        for (int i = 0; i < 8; i++) begin
            step("gap_on",  1'b1, 32'hFFFF_FFFF, 1'b0, 3'd3);
            step("gap_off", 1'b0, 32'd0, 1'b0, 3'd3);
            step("gap_off", 1'b0, 32'd0, 1'b0, 3'd3);
        end
        chk("gap.lit", average_o, 32'hFFFF_FFFF);

        // Clear with simultaneous valid discards the sample and relatches k=0
        step("mc_clr", 1'b0, 32'd0, 1'b1, 3'd2);
        step("mc0", 1'b1, 32'd40, 1'b0, 3'd2);
        step("mc1", 1'b1, 32'd44, 1'b0, 3'd2);
        step("mc_cv", 1'b1, 32'd55, 1'b1, 3'd0);
        step("mc7", 1'b1, 32'd7, 1'b0, 3'd0);
        chk("mc7.lit", average_o, 32'd7);

        // win_log2_i ignored without clear
        for (int i = 0; i < 4; i++) step("ign", 1'b1, $urandom, 1'b0, 3'd3);

        // Clamp 7 -> 4: full only after the 16th sample
        step("clamp_clr", 1'b0, 32'd0, 1'b1, 3'd7);
        for (int i = 0; i < 18; i++) step("clamp", 1'b1, $urandom, 1'b0, 3'd7);

        // Random traffic with occasional clears and window changes
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), $urandom,
                 ($urandom_range(0, 24) == 0), 3'($urandom_range(0, 7)));
        end

        // Asynchronous reset between edges, then restart with k=1
        step("pre_rst", 1'b1, 32'd123, 1'b0, 3'd1);
        reset = 1'b1;
        #2;
        model_reset();
        chk_outs("async_rst");
        #1;
        reset = 1'b0;
        step("rst6",  1'b1, 32'd6,  1'b0, 3'd1);
        chk("rst6.lit", average_o, 32'd3);
        step("rst10", 1'b1, 32'd10, 1'b0, 3'd1);
        chk("rst10.lit", average_o, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
